piso_serializer: RTL and testbench
==================================

# piso_serializer

Parallel-in, serial-out transmitter that converts a WIDTH-bit word into a bit-serial stream, LSB first, one bit per clock. It is the transmit end of the serial link whose receive end is our serial-in shift register, which shifts new bits in at the MSB. A frame sent here is reassembled in the original bit order by that receiver after WIDTH shifts. A valid/ready handshake on the parallel side accepts words. A valid/last qualifier pair on the serial side marks frame boundaries.

## Interface
Parameters:
- WIDTH, default 8: data word width in bits; legal range is WIDTH >= 2.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- d  input  WIDTH  parallel word to transmit.
- load  input  1  word-valid strobe; d is captured when load && ready at a rising edge.
- ready  output  1  transmitter can accept a word this cycle.
- sout  output  1  serial data bit.
- sout_valid  output  1  sout carries a frame bit this cycle.
- sout_last  output  1  sout carries the final bit of the current frame.

## Operation
- States:
  - IDLE: no frame in progress.
  - SHIFT: frame being shifted out.
- Internal state:
  - shift register sr, FRAME bits wide, where FRAME = WIDTH, or WIDTH+1 with parity.
  - bit counter cnt, $clog2(FRAME) bits wide, counting 0..FRAME-1.
- ready:
  - ready = (state == IDLE) || (state == SHIFT && cnt == FRAME-1).
  - This allows back-to-back frames with no gap cycle.
- Accept (load && ready at an edge):
  - sr <= frame word (d, plus the parity bit if enabled).
  - cnt <= 0.
  - state <= SHIFT.
- In SHIFT, when no accept occurs:
  - if cnt < FRAME-1: sr <= sr >> 1 (zero fill) and cnt <= cnt + 1.
  - if cnt == FRAME-1: state <= IDLE.
- Outputs:
  - sout = sr[0] when in SHIFT, otherwise 0.
  - sout_valid = (state == SHIFT).
  - sout_last = (state == SHIFT && cnt == FRAME-1).
  - All outputs are derived from registered state only; there is no combinational path from d or load to sout.
- load while ready = 0: ignored. d is not sampled and the frame in flight is undisturbed.
- load held high continuously: a new word is accepted on every ready edge, giving a continuous stream.
- reset_n low at any time, including mid-frame:
  - state = IDLE, sr = 0, cnt = 0 immediately, without waiting for a clock.
  - The frame in flight is dropped with no partial completion.

## Timing
- Reset values: ready = 1, sout = 0, sout_valid = 0, sout_last = 0.
- Latency: if the accept happens at edge k, bit 0 appears on sout in the cycle following edge k. Bit i appears in the cycle following edge k+i.
- Frame duration: sout_valid is high for exactly FRAME consecutive cycles per accepted word.
- Frame end: sout_last is high only in the final bit cycle, which is the same cycle in which ready is re-asserted.
- Back-to-back: an accept in the last-bit cycle puts bit 0 of the next word on sout in the very next cycle. sout_valid stays continuously high.
- Removal of reset_n is asynchronous. First accept is possible at the first rising edge after reset_n goes high.

## Configuration
- Macro: PISO_PARITY_EN.
- Defined:
  - FRAME = WIDTH+1.
  - An even-parity bit (^d) is sent after the MSB as the final frame bit, and sout_last marks it.
  - ready returns in that parity cycle.
- Undefined:
  - FRAME = WIDTH and no parity logic is present.
  - sout_last marks bit WIDTH-1.

## Test plan
- Reset: drive reset_n = 0 for 2 cycles with load = 1 and d = 8'hFF -> ready = 1, sout = 0, sout_valid = 0, sout_last = 0 throughout. Release -> idle, with nothing transmitted before the first accept.
- Single frame: accept 8'hA5 -> sout = 1,0,1,0,0,1,0,1 over the next 8 cycles, sout_valid high for exactly 8 cycles, sout_last only on the 8th, ready low in cycles 1-7.
- Back-to-back: load held high with 8'h01 then 8'h80 (second accepted in the last-bit cycle) -> 16 contiguous valid cycles: 1,0,0,0,0,0,0,0,0,0,0,0,0,0,0,1, with sout_last on cycles 8 and 16.
- Busy load: accept 8'h0F, then pulse load with d = 8'hF0 in bit cycle 3 -> pulse ignored; stream stays 1,1,1,1,0,0,0,0; ready is not asserted early.
- Mid-frame reset: accept 8'hFF, assert reset_n = 0 during bit cycle 4 -> sout, sout_valid and sout_last drop to 0 immediately and ready = 1. After release no residual bits are emitted.
- Parity (PISO_PARITY_EN defined): 8'h07 -> 9 valid cycles, 9th bit 1. 8'h03 -> 9th bit 0. sout_last on bit 9 in both cases.

Source files
------------

// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in, serial-out transmitter, LSB first, one bit per clock.
// Ports: clk, reset_n (async, active-low), d/load/ready (parallel handshake),
//        sout/sout_valid/sout_last (serial stream with frame qualifiers).
// Build option: define PISO_PARITY_EN to append an even-parity bit after the MSB.
module piso_serializer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] d,
    input  logic             load,
    output logic             ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             sout_last
);

`ifdef PISO_PARITY_EN
    localparam int FRAME = WIDTH + 1;
`else
    localparam int FRAME = WIDTH;
`endif
    localparam int CW = $clog2(FRAME);
    localparam logic [CW-1:0] LAST = CW'(FRAME - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           r_state;
    logic [FRAME-1:0] r_sr;
    logic [CW-1:0]    r_cnt;

    state_t           w_state_nxt;
    logic [FRAME-1:0] w_sr_nxt;
    logic [CW-1:0]    w_cnt_nxt;
    logic [FRAME-1:0] w_frame;
    logic             w_last;
    logic             w_accept;

`ifdef PISO_PARITY_EN
    assign w_frame = {^d, d};
`else
    assign w_frame = d;
`endif

    assign w_last   = (r_state == SHIFT) && (r_cnt == LAST);
    // Ready re-opens in the last-bit cycle so frames can run back-to-back.
    assign ready    = (r_state == IDLE) || w_last;
    assign w_accept = load && ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_sr    <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_sr    <= w_sr_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_sr_nxt    = r_sr;
        w_cnt_nxt   = r_cnt;
        if (w_accept) begin
            w_state_nxt = SHIFT;
            w_sr_nxt    = w_frame;
            w_cnt_nxt   = '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    w_state_nxt = IDLE;
                end
                SHIFT: begin
                    if (w_last) begin
                        w_state_nxt = IDLE;
                    end else begin
                        w_sr_nxt  = r_sr >> 1;
                        w_cnt_nxt = r_cnt + CW'(1);
                    end
                end
            endcase
        end
    end

    assign sout_valid = (r_state == SHIFT);
    assign sout       = (r_state == SHIFT) && r_sr[0];
    assign sout_last  = w_last;

endmodule

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer: randomized and directed stimulus for piso_serializer,
// compared each cycle against a queue-based model of the outgoing bit stream.
module tb_piso_serializer;

    localparam int WIDTH = 8;
`ifdef PISO_PARITY_EN
    localparam int FRAME = WIDTH + 1;
`else
    localparam int FRAME = WIDTH;
`endif

    logic             clk;
    logic             reset_n;
    logic [WIDTH-1:0] d;
    logic             load;
    logic             ready;
    logic             sout;
    logic             sout_valid;
    logic             sout_last;

    int n_checks;
    int n_fail;
    int n_frames;

    // Bits still to be shown on sout; element 0 is the bit currently on the wire.
    bit q[$];

    piso_serializer #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .d          (d),
        .load       (load),
        .ready      (ready),
        .sout       (sout),
        .sout_valid (sout_valid),
        .sout_last  (sout_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic push_frame(input logic [WIDTH-1:0] w);
        q.delete();
        for (int i = 0; i < WIDTH; i++) q.push_back(w[i]);
`ifdef PISO_PARITY_EN
        q.push_back(^w);
`endif
        n_frames++;
    endtask

    task automatic compare();
        check("valid", 32'(sout_valid), 32'(q.size() > 0));
        check("sout",  32'(sout),       32'((q.size() > 0) ? q[0] : 1'b0));
        check("last",  32'(sout_last),  32'(q.size() == 1));
        check("ready", 32'(ready),      32'(q.size() <= 1));
    endtask

    task automatic step();
        @(posedge clk);
        if (!reset_n) begin
            q.delete();
        end else if (load && q.size() <= 1) begin
            push_frame(d);
        end else if (q.size() > 0) begin
            void'(q.pop_front());
        end
        #1;
        compare();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        n_frames = 0;
        reset_n  = 1'b0;
        load     = 1'b1;
        d        = 8'hFF;
        #1;
        compare();
        run(2);
        reset_n = 1'b1;
        load    = 1'b0;
        d       = '0;
        run(3);

        // single frame
        load = 1'b1;
        d    = 8'hA5;
        step();
        load = 1'b0;
        d    = 8'h00;
        run(FRAME + 2);

        // back-to-back with load held high
        load = 1'b1;
        d    = 8'h01;
        step();
        d = 8'h80;
        run(FRAME);
        load = 1'b0;
        run(FRAME + 2);

        // load while busy is ignored
        load = 1'b1;
        d    = 8'h0F;
        step();
        load = 1'b0;
        run(2);
        load = 1'b1;
        d    = 8'hF0;
        step();
        load = 1'b0;
        d    = 8'h00;
        run(FRAME + 1);

        // reset in the middle of a frame
        load = 1'b1;
        d    = 8'hFF;
        step();
        load = 1'b0;
        run(3);
        reset_n = 1'b0;
        #1;
        q.delete();
        compare();
        run(1);
        reset_n = 1'b1;
        run(FRAME + 2);

        // parity-sensitive words
        load = 1'b1;
        d    = 8'h07;
        step();
        d = 8'h03;
        run(FRAME);
        load = 1'b0;
        run(FRAME + 1);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            load = ($urandom_range(0, 3) != 0);
            d    = WIDTH'($urandom);
            step();
        end
        load = 1'b0;
        run(FRAME + 1);

        check("frames_seen", 32'(n_frames > 10), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
